// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store controller.
// Lanes are little-endian: byte 0 lives in bits [7:0].
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
            SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  addr_lo,
                                               input logic [1:0]  size);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) r[31:16] = wdata[15:0];
                else            r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store controller between the core and a word-addressed data memory.
// Sub-word stores are read-modify-write; outputs are decoded from state and latched request.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          busy,
    output logic [31:0]   mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_merge;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_err;
    logic [AW-1:0] w_req_idx;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_req_idx = {2'b00, req_addr[AW-1:2]};

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            SZ_BYTE: w_err = 1'b0;
            SZ_HALF: w_err = req_addr[0];
            SZ_WORD: w_err = |req_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if (w_req_idx >= AW'(DEPTH)) w_err = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err)                   w_next = ST_RESP;
                    else if (!req_we)            w_next = ST_LOAD;
                    else if (req_size == SZ_WORD) w_next = ST_WRITE;
                    else                         w_next = ST_RMW_RD;
                end
            end
            ST_LOAD:   w_next = ST_RESP;
            ST_RMW_RD: w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_RESP;
            ST_RESP:   if (resp_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request fields are frozen at accept so mem_addr holds for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_merge  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
                r_rdata  <= '0;
            end
            if (r_state == ST_LOAD)
                r_rdata <= lane_extract(mem_rdata, r_addr[1:0], r_size, r_signed);
            if (r_state == ST_RMW_RD)
                r_merge <= mem_rdata;
        end
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        busy       = (r_state != ST_IDLE);
        resp_valid = (r_state == ST_RESP);
        resp_err   = (r_state == ST_RESP) && r_err;
        resp_rdata = (r_state == ST_RESP) ? r_rdata : 32'h0;
        mem_read   = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
        mem_write  = (r_state == ST_WRITE);
        mem_addr   = 32'(r_addr[AW-1:2]);
        mem_wdata  = 32'h0;
        if (r_state == ST_WRITE) begin
            if (r_we && (r_size == SZ_WORD)) mem_wdata = r_wdata;
            else mem_wdata = lane_merge(r_merge, r_wdata, r_addr[1:0], r_size);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural combinational-read data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;

    int          tot_rd = 0, tot_wr = 0, tot_both = 0;
    logic [31:0] last_wdata = 32'h0, last_waddr = 32'h0;
    int          n_chk = 0, n_err = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (mem_read) tot_rd <= tot_rd + 1;
        if (mem_write) begin
            tot_wr     <= tot_wr + 1;
            last_wdata <= mem_wdata;
            last_waddr <= mem_addr;
        end
        if (mem_read && mem_write) tot_both <= tot_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request from IDLE (#1 after a posedge) and complete the handshake.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int nrd, output int nwr);
        int rd0, wr0;
        rd0 = tot_rd; wr0 = tot_wr;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_size = 2'b11; req_wdata = 32'h0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        nrd = tot_rd - rd0; nwr = tot_wr - wr0;
    endtask

    logic [31:0] rd, hold_rd, before4;
    logic        er;
    int          lat, nrd, nwr, n;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) preload(8'(i), 32'h0);

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, nrd, nwr);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_writes", 32'(nwr), 32'd1);
        chk("sw_reads", 32'(nrd), 32'd0);
        chk("sw_addr", last_waddr, 32'd4);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_resp_rdata", rd, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_reads", 32'(nrd), 32'd1);

        // Byte store via read-modify-write, then byte loads
        preload(8'd4, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAA, rd, er, lat, nrd, nwr);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_reads", 32'(nrd), 32'd1);
        chk("sb_writes", 32'(nwr), 32'd1);
        chk("sb_wdata", last_wdata, 32'h1122AA44);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat, nrd, nwr);
        chk("lbu", rd, 32'h000000AA);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb", rd, 32'hFFFFFFAA);
        chk("lb_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb_lane3", rd, 32'h00000011);

        // Halfword store, then halfword loads
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, rd, er, lat, nrd, nwr);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_wdata", last_wdata, 32'h8001AA44);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat, nrd, nwr);
        chk("lh", rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, nrd, nwr);
        chk("lhu", rd, 32'h00008001);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("lh_low", rd, 32'hFFFFAA44);

        // Error cases: no strobes, one-cycle response, memory untouched
        before4 = mem[4];
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, er, lat, nrd, nwr);
        chk("err_lw_mis", {rd[30:0], er}, 32'h1);
        chk("err_lw_lat", 32'(lat), 32'd1);
        chk("err_lw_strobes", 32'(nrd + nwr), 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, er, lat, nrd, nwr);
        chk("err_lh_mis", {rd[30:0], er}, 32'h1);
        chk("err_lh_strobes", 32'(nrd + nwr), 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, rd, er, lat, nrd, nwr);
        chk("err_size", {rd[30:0], er}, 32'h1);
        chk("err_size_strobes", 32'(nrd + nwr), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat, nrd, nwr);
        chk("err_range", {rd[30:0], er}, 32'h1);
        chk("err_range_rdata", rd, 32'h0);
        chk("err_range_lat", 32'(lat), 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h0BAD0BAD, rd, er, lat, nrd, nwr);
        chk("ok_last_word", {31'b0, er}, 32'h0);
        chk("mem_unchanged", mem[4], before4);

        // Response back-pressure
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        hold_rd = resp_rdata;
        chk("hold_data", hold_rd, 32'h8001AA44);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {resp_valid, req_ready, resp_err}, 3'b100);
            chk("hold_rdata", resp_rdata, hold_rd);
        end
        resp_ready = 1'b1;
        #1;
        chk("hs_req_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_idle", {req_ready, busy, resp_valid}, 3'b100);

        // Reset during the write phase of a byte store
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h21; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        chk("rmw_write", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_mem_write", {30'b0, mem_write, mem_read}, 32'h0);
        chk("async_ctrl", {req_ready, busy, resp_valid, resp_err}, 4'b1000);
        chk("async_addr_wdata", mem_addr | mem_wdata | resp_rdata, 32'h0);
        @(posedge clk); #1;
        chk("rst_no_resp", 32'(resp_valid), 32'd0);
        chk("rst_no_write", mem[8], 32'h0);
        reset = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr);
        chk("lw_after_rst", rd, 32'h0);
        chk("lw_after_rst_err", 32'(er), 32'd0);

        chk("never_both", 32'(tot_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
